// File: rtl/signsum_decoder_if.sv
// Handshake/data bundle between the signed ripple adder and the sign-magnitude decoder.
interface signsum_decoder_if #(parameter int bitNumber = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [bitNumber-1:0] Sum;
  logic                 A_sign;
  logic                 B_sign;
  logic                 out_valid;
  logic                 out_ready;
  logic                 Sign;
  logic [bitNumber-2:0] Mag;
  logic                 Ovf;

  modport master (
    output in_valid, Sum, A_sign, B_sign, out_ready,
    input  in_ready, out_valid, Sign, Mag, Ovf
  );
  modport slave (
    input  in_valid, Sum, A_sign, B_sign, out_ready,
    output in_ready, out_valid, Sign, Mag, Ovf
  );
endinterface

// File: rtl/signsum_decoder.sv
// Bit-serial (LSB first) two's-complement to sign-magnitude converter with overflow flag.
// Optional `SIGNDEC_SATURATE_EN: overflowed results saturate to full-scale magnitude.
module signsum_decoder #(
  parameter int bitNumber = 8
) (
  input logic               clk1,
  input logic               rst,
  signsum_decoder_if.slave  bus
);
  localparam int             CW      = $clog2(bitNumber);
  localparam logic [CW-1:0]  LAST    = CW'(bitNumber - 1);
  localparam logic [CW-1:0]  LASTBIT = CW'(bitNumber - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               r_state, w_next;
  logic [bitNumber-1:0] r_sh;
  logic [bitNumber-2:0] r_acc, r_mag;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg, r_seen, r_ovf_pend, r_sat_sign;
  logic                 r_sign, r_ovf;
  logic                 w_capture, w_commit, w_bit, w_sgn_ovf, w_min_neg;
  logic                 w_in_ready, w_out_valid;
  logic                 w_sign_nxt;
  logic [bitNumber-2:0] w_mag_nxt;

  assign w_capture = (r_state == IDLE) && bus.in_valid;
  assign w_commit  = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_sgn_ovf = (bus.A_sign == bus.B_sign) && (bus.Sum[bitNumber-1] != bus.A_sign);
  assign w_min_neg = (bus.Sum == {1'b1, {(bitNumber-1){1'b0}}});
  // Copy-until-first-one: bits after the first set bit are inverted for negatives.
  assign w_bit     = r_sh[0] ^ (r_neg & r_seen);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_mag_nxt  = r_acc;
    w_sign_nxt = r_neg & (|r_acc);
`ifdef SIGNDEC_SATURATE_EN
    if (r_ovf_pend) begin
      w_mag_nxt  = '1;
      w_sign_nxt = r_sat_sign;
    end
`endif
  end

  // Bits 0..n-2 shift during cnt 0..n-2; the final SHIFT cycle commits the
  // result so DONE is entered n edges after the capture edge.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_sh       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_seen     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_sat_sign <= 1'b0;
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_ovf      <= 1'b0;
    end else if (w_capture) begin
      r_sh       <= bus.Sum;
      r_neg      <= bus.Sum[bitNumber-1];
      r_seen     <= 1'b0;
      r_cnt      <= '0;
      r_ovf_pend <= w_sgn_ovf | w_min_neg;
      r_sat_sign <= w_sgn_ovf ? bus.A_sign : 1'b1;
    end else if (r_state == SHIFT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt <= LASTBIT) begin
        r_sh   <= r_sh >> 1;
        r_acc  <= {w_bit, r_acc[bitNumber-2:1]};
        r_seen <= r_seen | r_sh[0];
      end
      if (w_commit) begin
        r_sign <= w_sign_nxt;
        r_mag  <= w_mag_nxt;
        r_ovf  <= r_ovf_pend;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.Sign      = r_sign;
  assign bus.Mag       = r_mag;
  assign bus.Ovf       = r_ovf;
endmodule

// File: tb/tb_signsum_decoder.sv
// Randomized and directed bench for signsum_decoder against an arithmetic reference model.
module tb_signsum_decoder;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  signsum_decoder_if #(.bitNumber(8)) bus ();
  signsum_decoder #(.bitNumber(8)) dut (.clk1(clk1), .rst(rst), .bus(bus.slave));

  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: interpret Sum as a signed integer and take sign and |value| mod 2^(n-1).
  function automatic void model(input logic [7:0] s, input logic a, input logic b,
                                output logic sg, output logic [6:0] mg, output logic ov);
    int   sv, am;
    logic wrap;
    sv   = (s >= 8'd128) ? int'(s) - 256 : int'(s);
    wrap = (a == b) && ((sv < 0) != a);
    ov   = wrap || (sv == -128);
    am   = (sv < 0) ? -sv : sv;
    mg   = 7'(am % 128);
    sg   = (sv < 0) && (mg != 7'd0);
`ifdef SIGNDEC_SATURATE_EN
    if (ov) begin
      mg = 7'h7f;
      sg = wrap ? a : 1'b1;
    end
`endif
  endfunction

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk1);
      lat++;
    end
    chk({tag, "_latency"}, lat, 8);
  endtask

  task automatic check_result(input string tag, input logic [7:0] s, input logic a, input logic b);
    logic sg, ov;
    logic [6:0] mg;
    model(s, a, b, sg, mg, ov);
    chk({tag, "_sign"}, bus.Sign, sg);
    chk({tag, "_mag"},  bus.Mag,  mg);
    chk({tag, "_ovf"},  bus.Ovf,  ov);
  endtask

  // Drive one word from IDLE, stall the consumer, then complete the handshake.
  task automatic run_word(input string tag, input logic [7:0] s, input logic a, input logic b,
                          input int stall);
    @(negedge clk1);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.Sum = s; bus.A_sign = a; bus.B_sign = b;
    @(negedge clk1);
    bus.in_valid = 1'b0;
    bus.Sum = 8'($urandom);
    wait_done(tag);
    check_result(tag, s, a, b);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk1);
      chk({tag, "_stall_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_stall_ready"}, bus.in_ready, 1'b0);
      check_result({tag, "_stall"}, s, a, b);
    end
    bus.out_ready = 1'b1;
    @(negedge clk1);
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, bus.in_ready, 1'b1);
    chk({tag, "_idle_ov"}, bus.out_valid, 1'b0);
    check_result({tag, "_idle_hold"}, s, a, b);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.Sum = '0; bus.A_sign = 1'b0; bus.B_sign = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk1);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sign",      bus.Sign,      1'b0);
    chk("rst_mag",       bus.Mag,       7'd0);
    chk("rst_ovf",       bus.Ovf,       1'b0);
    rst = 1'b0;

    run_word("pos5",   8'h05, 1'b0, 1'b0, 2);
    run_word("neg5",   8'hFB, 1'b1, 1'b1, 1);
    run_word("wrap96", 8'h96, 1'b0, 1'b0, 0);
    run_word("min80",  8'h80, 1'b1, 1'b1, 0);
    run_word("min80p", 8'h80, 1'b0, 1'b0, 0);
    run_word("neg5b",  8'hFB, 1'b1, 1'b1, 0);

    // Asynchronous reset mid-conversion discards the word.
    @(negedge clk1);
    bus.in_valid = 1'b1; bus.Sum = 8'hFB; bus.A_sign = 1'b1; bus.B_sign = 1'b1;
    @(negedge clk1);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready",  bus.in_ready,  1'b1);
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_sign",      bus.Sign,      1'b0);
    chk("arst_mag",       bus.Mag,       7'd0);
    chk("arst_ovf",       bus.Ovf,       1'b0);
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    repeat (9) @(negedge clk1);
    chk("arst_discard", bus.out_valid, 1'b0);
    run_word("post_rst", 8'h05, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid held high and a 5-cycle consumer stall.
    @(negedge clk1);
    bus.in_valid = 1'b1; bus.Sum = 8'h00; bus.A_sign = 1'b0; bus.B_sign = 1'b0;
    @(negedge clk1);
    bus.Sum = 8'h7F;
    wait_done("b2b0");
    check_result("b2b0", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      chk("b2b0_stall_ready", bus.in_ready, 1'b0);
      check_result("b2b0_stall", 8'h00, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk1);
    bus.out_ready = 1'b0;
    chk("b2b_idle_ready", bus.in_ready, 1'b1);
    @(negedge clk1);
    bus.in_valid = 1'b0;
    chk("b2b1_captured", bus.in_ready, 1'b0);
    wait_done("b2b1");
    chk("b2b1_sign", bus.Sign, 1'b0);
    chk("b2b1_mag",  bus.Mag,  7'h7F);
    check_result("b2b1", 8'h7F, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk1);
    bus.out_ready = 1'b0;

    for (int k = 0; k < 40; k++)
      run_word("rand", 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
